// File: rtl/sm83_bus_target.sv
// sm83_bus_target: responder end of the sm83_core bus serving WRAM/echo, HRAM, IF/IE and the timer.
// The DIV/TIMA/TMA/TAC timer is only built when SM83_TIMER_EN is defined.
module sm83_bus_target #(
  parameter int unsigned WRAM_AW      = 13,
  parameter logic [7:0]  UNMAPPED_VAL = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] r_addr,
  output logic [7:0]  r_data,
  input  logic [15:0] w_addr,
  input  logic [7:0]  w_data,
  input  logic        w_wen,
  input  logic [4:0]  irq_set,
  output logic [4:0]  irq_pending
);

  localparam int unsigned WRAM_SZ = 1 << WRAM_AW;

  function automatic logic is_wram(input logic [15:0] a);
    return (a[15:13] == 3'b110) || ((a[15:13] == 3'b111) && (a < 16'hFE00));
  endfunction

  function automatic logic is_hram(input logic [15:0] a);
    return (a[15:7] == 9'h1FF) && (a[6:0] != 7'h7F);
  endfunction

  logic [7:0] wram_q [WRAM_SZ];
  logic [7:0] hram_q [127];
  logic [7:0] r_data_q, r_data_d;
  logic [4:0] if_q, if_d;
  logic [7:0] ie_q, ie_d;
  logic [4:0] irq_pending_q, irq_pending_d;
  logic       wr_if_s, wr_ie_s, ovf_s;

  assign wr_if_s     = w_wen && (w_addr == 16'hFF0F);
  assign wr_ie_s     = w_wen && (w_addr == 16'hFFFF);
  assign r_data      = r_data_q;
  assign irq_pending = irq_pending_q;

  // RAM contents survive reset; echo space lands on the same WRAM index.
  always_ff @(posedge clk) begin
    if (w_wen && is_wram(w_addr)) begin
      wram_q[w_addr[WRAM_AW-1:0]] <= w_data;
    end
    if (w_wen && is_hram(w_addr)) begin
      hram_q[w_addr[6:0]] <= w_data;
    end
  end

`ifdef SM83_TIMER_EN
  logic [15:0] sys_cnt_q, sys_cnt_d;
  logic [7:0]  tima_q, tima_d, tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic        tick_q, tick_d, sel_bit_s, inc_s;
  logic        wr_div_s, wr_tima_s, wr_tma_s, wr_tac_s;

  assign wr_div_s  = w_wen && (w_addr == 16'hFF04);
  assign wr_tima_s = w_wen && (w_addr == 16'hFF05);
  assign wr_tma_s  = w_wen && (w_addr == 16'hFF06);
  assign wr_tac_s  = w_wen && (w_addr == 16'hFF07);

  // tick_q holds last cycle's tick, so a drop forced by a DIV or TAC write still counts.
  always_comb begin
    case (tac_q[1:0])
      2'b00:   sel_bit_s = sys_cnt_q[9];
      2'b01:   sel_bit_s = sys_cnt_q[3];
      2'b10:   sel_bit_s = sys_cnt_q[5];
      2'b11:   sel_bit_s = sys_cnt_q[7];
      default: sel_bit_s = 1'b0;
    endcase
    tick_d    = tac_q[2] & sel_bit_s;
    inc_s     = tick_q & ~tick_d;
    sys_cnt_d = wr_div_s ? 16'h0000 : sys_cnt_q + 16'h0001;
    tma_d     = wr_tma_s ? w_data : tma_q;
    tac_d     = wr_tac_s ? w_data[2:0] : tac_q;
    ovf_s     = inc_s && (tima_q == 8'hFF) && !wr_tima_s;
    if (wr_tima_s) begin
      tima_d = w_data;
    end else if (ovf_s) begin
      tima_d = tma_d;
    end else if (inc_s) begin
      tima_d = tima_q + 8'h01;
    end else begin
      tima_d = tima_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sys_cnt_q <= 16'h0000;
      tima_q    <= 8'h00;
      tma_q     <= 8'h00;
      tac_q     <= 3'b000;
      tick_q    <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tima_q    <= tima_d;
      tma_q     <= tma_d;
      tac_q     <= tac_d;
      tick_q    <= tick_d;
    end
  end
`else
  assign ovf_s = 1'b0;
`endif

  // Read decode uses pre-write state, giving read-first behaviour on collisions.
  always_comb begin
    r_data_d = UNMAPPED_VAL;
    if (is_wram(r_addr)) begin
      r_data_d = wram_q[r_addr[WRAM_AW-1:0]];
    end else if (is_hram(r_addr)) begin
      r_data_d = hram_q[r_addr[6:0]];
    end else begin
      case (r_addr)
        16'hFF0F: r_data_d = {3'b111, if_q};
        16'hFFFF: r_data_d = ie_q;
`ifdef SM83_TIMER_EN
        16'hFF04: r_data_d = sys_cnt_q[15:8];
        16'hFF05: r_data_d = tima_q;
        16'hFF06: r_data_d = tma_q;
        16'hFF07: r_data_d = {5'b11111, tac_q};
`endif
        default:  r_data_d = UNMAPPED_VAL;
      endcase
    end
    if_d          = (wr_if_s ? w_data[4:0] : if_q) | irq_set | {2'b00, ovf_s, 2'b00};
    ie_d          = wr_ie_s ? w_data : ie_q;
    irq_pending_d = if_d & ie_d[4:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_q      <= UNMAPPED_VAL;
      if_q          <= 5'b00000;
      ie_q          <= 8'h00;
      irq_pending_q <= 5'b00000;
    end else begin
      r_data_q      <= r_data_d;
      if_q          <= if_d;
      ie_q          <= ie_d;
      irq_pending_q <= irq_pending_d;
    end
  end

endmodule

// File: tb/tb_sm83_bus_target.sv
// Self-checking bench for sm83_bus_target: directed steps then random traffic against a reference model.
// Timer-specific steps are selected by SM83_TIMER_EN, matching the RTL build.
module tb_sm83_bus_target;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] r_addr, w_addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [4:0]  irq_set;
  logic [7:0]  r_data;
  logic [4:0]  irq_pending;

  int checks   = 0;
  int failures = 0;

  sm83_bus_target dut (
    .clk(clk), .rst(rst), .r_addr(r_addr), .r_data(r_data),
    .w_addr(w_addr), .w_data(w_data), .w_wen(w_wen),
    .irq_set(irq_set), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_mem [int];
  logic [4:0]  m_if;
  logic [7:0]  m_ie;
  logic [15:0] m_sys;
  logic [7:0]  m_tima, m_tma;
  logic [2:0]  m_tac;
  logic        m_prev;
  logic [7:0]  e_rdata;
  logic        e_rknown;
  logic [4:0]  e_irq;
  int          sel_tab [4] = '{9, 3, 5, 7};

  function automatic int mkey(input logic [15:0] a);
    int off;
    if (a >= 16'hC000 && a < 16'hFE00) begin
      off = int'(a) - 32'hC000;
      return 32'hC000 + (off % 8192);
    end
    if (a >= 16'hFF80 && a <= 16'hFFFE) return int'(a);
    return -1;
  endfunction

  function automatic logic [7:0] reg_read(input logic [15:0] a);
    case (a)
      16'hFF0F: return {3'b111, m_if};
      16'hFFFF: return m_ie;
`ifdef SM83_TIMER_EN
      16'hFF04: return m_sys[15:8];
      16'hFF05: return m_tima;
      16'hFF06: return m_tma;
      16'hFF07: return {5'b11111, m_tac};
`endif
      default:  return 8'hFF;
    endcase
  endfunction

  function automatic logic wr(input logic [15:0] a);
    return w_wen && (w_addr == a);
  endfunction

  function automatic logic m_tick();
    return m_tac[2] && m_sys[sel_tab[m_tac[1:0]]];
  endfunction

  task automatic model_edge();
    int key;
    logic tick, inc, ovf;
    if (rst) begin
      m_if = 5'h00; m_ie = 8'h00; m_sys = 16'h0000; m_tima = 8'h00; m_tma = 8'h00;
      m_tac = 3'b000; m_prev = 1'b0;
      e_rdata = 8'hFF; e_rknown = 1'b1; e_irq = 5'h00;
      return;
    end
    key = mkey(r_addr);
    if (key >= 0) begin
      e_rknown = m_mem.exists(key);
      e_rdata  = e_rknown ? m_mem[key] : 8'h00;
    end else begin
      e_rknown = 1'b1;
      e_rdata  = reg_read(r_addr);
    end
    key = mkey(w_addr);
    if (w_wen && key >= 0) m_mem[key] = w_data;
    ovf = 1'b0;
`ifdef SM83_TIMER_EN
    tick   = m_tick();
    inc    = m_prev && !tick;
    m_prev = tick;
    ovf    = inc && (m_tima == 8'hFF) && !wr(16'hFF05);
    if (wr(16'hFF06)) m_tma = w_data;
    if (wr(16'hFF05)) m_tima = w_data;
    else if (ovf) m_tima = m_tma;
    else if (inc) m_tima = m_tima + 8'h01;
    if (wr(16'hFF07)) m_tac = w_data[2:0];
    m_sys = wr(16'hFF04) ? 16'h0000 : m_sys + 16'h0001;
`else
    tick = 1'b0;
    inc  = tick;
`endif
    m_if = (wr(16'hFF0F) ? w_data[4:0] : m_if) | irq_set | (ovf ? 5'h04 : 5'h00);
    if (wr(16'hFFFF)) m_ie = w_data;
    e_irq = m_if & m_ie[4:0];
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    if (e_rknown) chk("r_data_model", {8'h00, r_data}, {8'h00, e_rdata});
    chk("irq_pending_model", {11'h000, irq_pending}, {11'h000, e_irq});
  endtask

  task automatic wr_step(input logic [15:0] a, input logic [7:0] d);
    w_wen = 1'b1; w_addr = a; w_data = d;
    step();
    w_wen = 1'b0;
  endtask

  task automatic rd_step(input logic [15:0] a);
    r_addr = a;
    step();
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] bases [4] = '{16'hC000, 16'hDFF0, 16'hE000, 16'hFDF0};
    logic [15:0] regs  [6] = '{16'hFF04, 16'hFF05, 16'hFF06, 16'hFF07, 16'hFF0F, 16'hFFFF};
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 15));
      4, 5:       return 16'hFF80 + 16'($urandom_range(0, 127));
      6:          return 16'hFF00 + 16'($urandom_range(0, 15));
      7:          return 16'($urandom_range(32'hFE00, 32'hFF7F));
      default:    return regs[$urandom_range(0, 5)];
    endcase
  endfunction

  initial begin
    logic found;
    rst = 1'b1; r_addr = 16'h0000; w_addr = 16'h0000; w_data = 8'h00; w_wen = 1'b0; irq_set = 5'h00;
    step();
    step();
    chk("reset_r_data", {8'h00, r_data}, 16'h00FF);
    chk("reset_irq", {11'h000, irq_pending}, 16'h0000);
    rst = 1'b0;
    rd_step(16'hFF0F); chk("reset_if", {8'h00, r_data}, 16'h00E0);
    rd_step(16'hFFFF); chk("reset_ie", {8'h00, r_data}, 16'h0000);

    // WRAM and echo
    wr_step(16'hC123, 8'h5A);
    rd_step(16'hE123); chk("echo_read", {8'h00, r_data}, 16'h005A);

    // HRAM bounds and read-first collision
    wr_step(16'hFF80, 8'h11);
    wr_step(16'hFFFE, 8'h22);
    rd_step(16'hFF7F); chk("ff7f_unmapped", {8'h00, r_data}, 16'h00FF);
    rd_step(16'hFF80); chk("hram_ff80", {8'h00, r_data}, 16'h0011);
    rd_step(16'hFFFE); chk("hram_fffe", {8'h00, r_data}, 16'h0022);
    r_addr = 16'hFFFE; wr_step(16'hFFFE, 8'h33);
    chk("read_first", {8'h00, r_data}, 16'h0022);
    rd_step(16'hFFFE); chk("after_write", {8'h00, r_data}, 16'h0033);

`ifdef SM83_TIMER_EN
    // Overflow reload and IF[2]
    wr_step(16'hFF0F, 8'h00);
    wr_step(16'hFFFF, 8'h00);
    wr_step(16'hFF06, 8'hF0);
    wr_step(16'hFF05, 8'hFE);
    wr_step(16'hFF07, 8'h05);
    found = 1'b0;
    r_addr = 16'hFF05;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (m_tima == 8'hF0) found = 1'b1;
    end
    if (!found) begin checks++; failures++; $error("FAIL t3_timeout observed=none expected=F0"); end
    rd_step(16'hFF05); chk("t3_tima", {8'h00, r_data}, 16'h00F0);
    rd_step(16'hFF0F); chk("t3_if", {8'h00, r_data}, 16'h00E4);
    chk("t3_irq_masked", {11'h000, irq_pending}, 16'h0000);
    wr_step(16'hFFFF, 8'h04);
    chk("t3_irq", {11'h000, irq_pending}, 16'h0004);

    // CPU write to TIMA in the overflow cycle wins
    wr_step(16'hFFFF, 8'h00);
    wr_step(16'hFF0F, 8'h00);
    wr_step(16'hFF05, 8'hFF);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_prev && !m_tick()) begin
        wr_step(16'hFF05, 8'h33);
        found = 1'b1;
      end else begin
        step();
      end
    end
    if (!found) begin checks++; failures++; $error("FAIL t4_timeout observed=none expected=inc"); end
    rd_step(16'hFF05); chk("t4_tima", {8'h00, r_data}, 16'h0033);
    rd_step(16'hFF0F); chk("t4_if", {8'h00, r_data}, 16'h00E0);

    // DIV write clears sys_cnt
    wr_step(16'hFF07, 8'h00);
    wr_step(16'hFF04, 8'h00);
    r_addr = 16'hFF04;
    for (int i = 0; i < 600 && m_sys != 16'h01FF; i++) step();
    rd_step(16'hFF04); chk("div_1ff", {8'h00, r_data}, 16'h0001);
    wr_step(16'hFF04, 8'hA5);
    rd_step(16'hFF04); chk("div_cleared", {8'h00, r_data}, 16'h0000);

    // Reset mid-count
    wr_step(16'hFFFF, 8'h1F);
    wr_step(16'hFF07, 8'h07);
    r_addr = 16'hFF05;
    for (int i = 0; i < 40; i++) step();
    rst = 1'b1; step();
    chk("t6_r_data", {8'h00, r_data}, 16'h00FF);
    rst = 1'b0;
    rd_step(16'hFF07); chk("t6_tac", {8'h00, r_data}, 16'h00F8);
    rd_step(16'hFF05); chk("t6_tima", {8'h00, r_data}, 16'h0000);
    rd_step(16'hFF0F); chk("t6_if", {8'h00, r_data}, 16'h00E0);
    rd_step(16'hFFFF); chk("t6_ie", {8'h00, r_data}, 16'h0000);
`else
    // Timer absent: FF04-FF07 unmapped, IF[2] only from irq_set or CPU
    wr_step(16'hFF05, 8'h12);
    wr_step(16'hFF07, 8'h05);
    rd_step(16'hFF04); chk("nt_div", {8'h00, r_data}, 16'h00FF);
    rd_step(16'hFF05); chk("nt_tima", {8'h00, r_data}, 16'h00FF);
    rd_step(16'hFF06); chk("nt_tma", {8'h00, r_data}, 16'h00FF);
    rd_step(16'hFF07); chk("nt_tac", {8'h00, r_data}, 16'h00FF);
    wr_step(16'hFF0F, 8'h00);
    irq_set = 5'h04; step(); irq_set = 5'h00;
    rd_step(16'hFF0F); chk("nt_if2", {8'h00, r_data}, 16'h00E4);
`endif

    // IF write racing irq_set keeps the set event
    irq_set = 5'h01; wr_step(16'hFF0F, 8'h00); irq_set = 5'h00;
    rd_step(16'hFF0F); chk("if_set_wins", {8'h00, r_data}, 16'h00E1);
    wr_step(16'hFFFF, 8'h01);
    chk("irq_vec0", {11'h000, irq_pending}, 16'h0001);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      r_addr  = pick_addr();
      w_addr  = pick_addr();
      w_data  = 8'($urandom);
      w_wen   = 1'($urandom_range(0, 1));
      irq_set = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'h00;
      rst     = ($urandom_range(0, 199) == 0);
      if (rst) w_wen = 1'b0;
      step();
    end
    rst = 1'b0; w_wen = 1'b0; irq_set = 5'h00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
